// File: rtl/fifo_qspi_pkg.sv
// Shared types and constants for the quad-SPI FIFO read-side serializer.
//   state_e        : serializer FSM states
//   NIB_W          : bits per quad-SPI beat
//   DEF_DATAWIDTH  : default FIFO word width
//   NIBS_PER_WORD  : nibbles per default-width word
//   NCNT_W         : nibble counter width for the default word
package fifo_qspi_pkg;

  localparam int unsigned NIB_W         = 4;
  localparam int unsigned DEF_DATAWIDTH = 64;
  localparam int unsigned NIBS_PER_WORD = DEF_DATAWIDTH / NIB_W;
  localparam int unsigned NCNT_W        = $clog2(NIBS_PER_WORD);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StEnd
  } state_e;

endpackage

// File: rtl/fifo_qspi_tx.sv
// Read-side FIFO consumer: pops DATAWIDTH-bit words (first-word-fall-through) and
// serializes them MSB nibble first onto a quad-SPI bus, one nibble per rclk.
// Ports:
//   rclk, rrstn       : clock and asynchronous active-low reset
//   start, len        : transfer request and byte count (accepted only when idle)
//   fifo_rdata        : FIFO head word, valid while fifo_rempty=0
//   fifo_rempty       : FIFO empty flag
//   fifo_ren          : pop strobe (combinational, never high while empty)
//   q_dout, q_valid   : quad data nibble and its qualifier
//   q_cs_n            : active-low chip select framing the transfer
//   busy, done        : transfer in progress / one-cycle end pulse
//   underrun          : sticky, FIFO ran dry while a nibble was owed
module fifo_qspi_tx
  import fifo_qspi_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
  parameter int unsigned LENW      = 16
) (
  input  logic                 rclk,
  input  logic                 rrstn,
  input  logic                 start,
  input  logic [LENW-1:0]      len,
  input  logic [DATAWIDTH-1:0] fifo_rdata,
  input  logic                 fifo_rempty,
  output logic                 fifo_ren,
  output logic [NIB_W-1:0]     q_dout,
  output logic                 q_valid,
  output logic                 q_cs_n,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun
);

  localparam int unsigned NibsPerWord = DATAWIDTH / NIB_W;
  localparam int unsigned NcntW       = $clog2(NibsPerWord);
  localparam logic [NcntW-1:0] NcntMax = NcntW'(NibsPerWord - 1);

  state_e                 state_q, state_d;
  logic [DATAWIDTH-1:0]   shreg_q, shreg_d;
  logic [NcntW-1:0]       nib_cnt_q, nib_cnt_d;
  logic [LENW-1:0]        bytes_left_q, bytes_left_d;
  logic                   first_q, first_d;       // no word popped yet this transfer
  logic                   underrun_q, underrun_d;
  logic                   zdone_q, zdone_d;       // done pulse for a zero-length start

  logic byte_end, word_end, last_nib;

  // Nibble counter counts down from an odd value, so an even count closes a byte.
  always_comb begin
    byte_end = ~nib_cnt_q[0];
    word_end = (nib_cnt_q == '0);
    last_nib = byte_end && (bytes_left_q == LENW'(1));
  end

  assign fifo_ren = ~fifo_rempty &&
                    ((state_q == StLoad) || ((state_q == StShift) && word_end && !last_nib));

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    nib_cnt_d    = nib_cnt_q;
    bytes_left_d = bytes_left_q;
    first_d      = first_q;
    underrun_d   = underrun_q;
    zdone_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            bytes_left_d = len;
            underrun_d   = 1'b0;
            first_d      = 1'b1;
            state_d      = StLoad;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (fifo_ren) begin
          shreg_d   = fifo_rdata;
          nib_cnt_d = NcntMax;
          first_d   = 1'b0;
          state_d   = StShift;
        end else if (!first_q) begin
          underrun_d = 1'b1;
        end
      end
      StShift: begin
        shreg_d   = shreg_q << NIB_W;
        nib_cnt_d = nib_cnt_q - NcntW'(1);
        if (byte_end) bytes_left_d = bytes_left_q - LENW'(1);
        if (last_nib) begin
          state_d = StEnd;
        end else if (word_end) begin
          if (fifo_ren) begin
            // Gapless reload: next word's first nibble follows immediately.
            shreg_d   = fifo_rdata;
            nib_cnt_d = NcntMax;
          end else begin
            underrun_d = 1'b1;
            state_d    = StLoad;
          end
        end
      end
      StEnd: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      nib_cnt_q    <= '0;
      bytes_left_q <= '0;
      first_q      <= 1'b0;
      underrun_q   <= 1'b0;
      zdone_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      nib_cnt_q    <= nib_cnt_d;
      bytes_left_q <= bytes_left_d;
      first_q      <= first_d;
      underrun_q   <= underrun_d;
      zdone_q      <= zdone_d;
    end
  end

  always_comb begin
    q_valid  = (state_q == StShift);
    q_dout   = q_valid ? shreg_q[DATAWIDTH-1 -: NIB_W] : '0;
    q_cs_n   = !((state_q == StLoad) || (state_q == StShift));
    busy     = (state_q != StIdle);
    done     = (state_q == StEnd) || zdone_q;
    underrun = underrun_q;
  end

endmodule

// File: tb/tb_fifo_qspi_tx.sv
module tb_fifo_qspi_tx;

  localparam int unsigned DW = 64;
  localparam int unsigned LW = 16;
  localparam int Horizon = 512;

  logic          rclk = 1'b0;
  logic          rrstn = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_rempty = 1'b1;
  logic          fifo_ren;
  logic [3:0]    q_dout;
  logic          q_valid, q_cs_n, busy, done, underrun;

  int n_tests = 0;
  int n_fail = 0;
  int pop_cnt = 0;

  logic [DW-1:0] fq[$];       // bench FIFO contents
  logic [DW-1:0] push_q[$];   // words waiting to enter the bench FIFO
  logic [DW-1:0] mq[$];       // reference model view of FIFO contents
  logic          m_ur = 1'b0; // reference model underrun flag
  int            lp_delay[$]; // late pushes for the next transfer: cycle offset ...
  logic [DW-1:0] lp_data[$];  // ... and word
  // Expected per-cycle {busy, q_cs_n, q_valid, done, fifo_ren, q_dout}
  logic [8:0]    ev [Horizon];

  fifo_qspi_tx #(.DATAWIDTH(DW), .LENW(LW)) dut (
    .rclk        (rclk),
    .rrstn       (rrstn),
    .start       (start),
    .len         (len),
    .fifo_rdata  (fifo_rdata),
    .fifo_rempty (fifo_rempty),
    .fifo_ren    (fifo_ren),
    .q_dout      (q_dout),
    .q_valid     (q_valid),
    .q_cs_n      (q_cs_n),
    .busy        (busy),
    .done        (done),
    .underrun    (underrun)
  );

  always #5 rclk = ~rclk;

  // First-word-fall-through FIFO: pop on the edge, new pushes land 2 time units later.
  always @(posedge rclk) begin
    if (fifo_ren && !fifo_rempty) begin
      void'(fq.pop_front());
      pop_cnt++;
    end
    #2;
    while (push_q.size() > 0) fq.push_back(push_q.pop_front());
    fifo_rempty = (fq.size() == 0);
    fifo_rdata  = fifo_rempty ? '0 : fq[0];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  function automatic logic [8:0] obs();
    return {busy, q_cs_n, q_valid, done, fifo_ren, q_dout};
  endfunction

  task automatic push(input logic [DW-1:0] w);
    push_q.push_back(w);
    mq.push_back(w);
  endtask

  task automatic push_due(input int d);
    foreach (lp_delay[k]) if (lp_delay[k] == d) push(lp_data[k]);
  endtask

  // Words present in cycle i: those already queued plus late pushes due by then.
  function automatic int avail(input int base, input int i);
    int a = base;
    foreach (lp_delay[k]) if (lp_delay[k] <= i) a++;
    return a;
  endfunction

  // Call at posedge+1; cycle 0 is the cycle in which start is high.
  task automatic run_xfer(input int l);
    int base, nw, nn, c, t, last, w, p0;
    logic ur;
    logic [DW-1:0] words[$];
    logic [DW-1:0] wd;
    base  = mq.size();
    words = mq;
    foreach (lp_data[k]) words.push_back(lp_data[k]);
    nw = (l + 7) / 8;
    nn = 2 * l;
    ur = 1'b0;
    for (int i = 0; i < Horizon; i++) ev[i] = 9'h080;
    if (l == 0) begin
      ev[1][5] = 1'b1;
      last = 0;
    end else begin
      c = 1;
      while (avail(base, c) < 1 && c < Horizon - 4) c++;
      ev[c][4] = 1'b1;
      t = c + 1;
      for (int n = 0; n < nn; n++) begin
        if (n > 0 && n % 16 == 0) begin
          w = n / 16;
          if (avail(base, t) > w) begin
            ev[t][4] = 1'b1;
            t = t + 1;
          end else begin
            ur = 1'b1;
            c = t + 1;
            while (avail(base, c) <= w && c < Horizon - 4) c++;
            ev[c][4] = 1'b1;
            t = c + 1;
          end
        end else if (n > 0) begin
          t = t + 1;
        end
        wd = words[n / 16] >> (DW - 4 - 4 * (n % 16));
        ev[t][6]   = 1'b1;
        ev[t][3:0] = wd[3:0];
      end
      last = t;
      for (int i = 1; i <= last + 1; i++) ev[i][8] = 1'b1;
      for (int i = 1; i <= last; i++) ev[i][7] = 1'b0;
      ev[last + 1][5] = 1'b1;
      m_ur = ur;
    end
    p0 = pop_cnt;
    start = 1'b1;
    len = LW'(l);
    push_due(0);
    for (int i = 0; i <= last + 2; i++) begin
      @(negedge rclk);
      check($sformatf("len%0d_cyc%0d", l, i), 64'(obs()), 64'(ev[i]));
      if (i == 1 && l != 0) check("underrun_clear", 64'(underrun), 64'(0));
      tick();
      start = 1'b0;
      push_due(i + 1);
    end
    check($sformatf("len%0d_underrun", l), 64'(underrun), 64'(m_ur));
    check($sformatf("len%0d_pops", l), 64'(pop_cnt - p0), 64'(nw));
    repeat (nw) void'(mq.pop_front());
    check("fifo_level", 64'(fq.size()), 64'(mq.size()));
    lp_delay.delete();
    lp_data.delete();
  endtask

  initial begin
    int p0, l, nw, need, d;
    logic [DW-1:0] w0, nib;

    // Reset state
    tick();
    tick();
    @(negedge rclk);
    check("reset_outputs", 64'(obs()), 64'(9'h080));
    check("reset_underrun", 64'(underrun), 64'(0));
    tick();
    rrstn = 1'b1;
    tick();

    // Single word, 8 bytes: nibbles 0..F
    push(64'h0123_4567_89AB_CDEF);
    tick();
    run_xfer(8);

    // Two words back to back, gapless
    push({16{4'h1}});
    push({16{4'h2}});
    tick();
    run_xfer(16);

    // Partial final word, following word stays queued
    push(64'hAABB_CCDD_EEFF_0011);
    push(64'h0F1E_2D3C_4B5A_6978);
    tick();
    run_xfer(3);

    // Leftover word only; second word arrives late -> stall and underrun
    lp_delay.push_back(22);
    lp_data.push_back({16{4'h3}});
    run_xfer(16);
    repeat (3) tick();
    check("underrun_sticky", 64'(underrun), 64'(1));

    // Zero-length start with data present: no frame, no pop
    w0 = 64'hFEDC_BA98_7654_3210;
    push(w0);
    tick();
    run_xfer(0);

    // Reset during the 7th nibble
    push(64'h5A5A_0000_FFFF_1234);
    tick();
    p0 = pop_cnt;
    start = 1'b1;
    len = LW'(16);
    tick();
    start = 1'b0;
    repeat (6) tick();
    @(negedge rclk);
    nib = w0 >> (DW - 4 * 6);
    check("pre_reset_nibble", 64'(q_dout), 64'(nib[3:0]));
    tick();
    rrstn = 1'b0;
    #1;
    check("abort_outputs", 64'(obs()), 64'(9'h080));
    check("abort_underrun", 64'(underrun), 64'(0));
    check("abort_pops", 64'(pop_cnt - p0), 64'(1));
    tick();
    rrstn = 1'b1;
    void'(mq.pop_front());
    m_ur = 1'b0;
    tick();
    run_xfer(8);

    // Randomized transfers with random FIFO arrival times
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 2)) push({$urandom, $urandom});
      tick();
      l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      nw = (l + 7) / 8;
      need = nw - mq.size();
      d = $urandom_range(0, 20);
      for (int k = 0; k < need; k++) begin
        lp_delay.push_back(d);
        lp_data.push_back({$urandom, $urandom});
        d = d + int'($urandom_range(0, 12));
      end
      run_xfer(l);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
